// File: rtl/bus_bridge.sv
// bus_bridge: responder end of the 65C02 core's address bus.
// Captures each core access while RDY=1, runs it on a req/ack memory port
// and holds the core with RDY=0 until the memory acknowledges. Read data is
// returned on the registered DB bus.
// Optional feature: define BUS_BRIDGE_TIMEOUT_EN to abort accesses that see
// no ack within TIMEOUT busy cycles (DB=8'hFF on reads, one-cycle bus_err).
module bus_bridge #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        RDY,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;

  // The counter is 8 bits wide, so anything outside 1..255 cannot be honoured.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_bridge: TIMEOUT must be in the range 1..255");
  end

`ifdef BUS_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] tmo_cnt;
  logic [7:0] tmo_next;

  // tmo_cnt holds the number of ack-less busy cycles already completed, so
  // the cycle that would bring it to TIMEOUT is the last one we wait.
  assign tmo_next = tmo_cnt + 8'd1;
`else
  assign bus_err = 1'b0;
`endif

  // Two-state access sequencer; RDY and mem_req are registered state decodes.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      RDY       <= 1'b1;
      mem_req   <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      DB        <= 8'h00;
`ifdef BUS_BRIDGE_TIMEOUT_EN
      bus_err   <= 1'b0;
      tmo_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Every RDY=1 cycle is a real core access; latch it unconditionally.
          mem_addr  <= AB;
          mem_we    <= WE;
          mem_wdata <= DO;
          mem_req   <= 1'b1;
          RDY       <= 1'b0;
          state     <= BUSY;
`ifdef BUS_BRIDGE_TIMEOUT_EN
          tmo_cnt   <= 8'd0;
          bus_err   <= 1'b0;
`endif
        end
        BUSY: begin
          if (mem_ack) begin
            if (!mem_we) begin
              DB <= mem_rdata;
            end
            mem_req <= 1'b0;
            RDY     <= 1'b1;
            state   <= IDLE;
          end
`ifdef BUS_BRIDGE_TIMEOUT_EN
          else if (tmo_next == TIMEOUT_CNT) begin
            if (!mem_we) begin
              DB <= 8'hFF;
            end
            mem_req <= 1'b0;
            RDY     <= 1'b1;
            state   <= IDLE;
            bus_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_next;
          end
`endif
        end
        default: begin
          state <= IDLE;
          RDY   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_bridge.md
# bus_bridge

Responder end of the 65C02 core's address bus. Each cycle the core presents a combinational address (ADH:ADL), write enable and write data; this block captures the access, runs it on a slower req/ack memory port, and stalls the core with RDY until the access completes. On completion it returns read data on DB. It sits between the core and external or peripheral memory, and replaces the zero-wait block-RAM path where memory cannot answer in one cycle.

## Interface
- TIMEOUT, 64: BUSY cycles without ack before abort. Range 1..255; used only with the macro.
- clk  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- AB  in  16  core address, {ADH, ADL}; unregistered.
- WE  in  1  core write enable for the access on AB.
- DO  in  8  core write data.
- DB  out  8  data bus to core; registered.
- RDY  out  1  1 = core advances; 0 = core holds all state and ignores DB.
- mem_req  out  1  memory request.
- mem_addr  out  16  latched address.
- mem_we  out  1  latched write enable.
- mem_wdata  out  8  latched write data.
- mem_rdata  in  8  read data, valid when mem_ack is 1.
- mem_ack  in  1  access complete, sampled only while in BUSY.
- bus_err  out  1  one-cycle timeout pulse; tied 0 without the macro.

## Operation
- Two-state FSM: IDLE and BUSY.
- RDY is 1 in IDLE and 0 in BUSY. It is a registered state decode, not combinational from mem_ack.
- **IDLE:**
  - Every cycle, capture AB, WE and DO into mem_addr, mem_we and mem_wdata.
  - Set mem_req=1 and go to BUSY.
  - IDLE always lasts exactly one cycle; every core cycle with RDY=1 issues an access.
- **BUSY:**
  - mem_req, mem_addr, mem_we and mem_wdata are held stable.
  - AB, WE and DO are ignored.
  - On mem_ack=1 with a read (mem_we=0): DB <= mem_rdata.
  - On mem_ack=1 with a write: DB unchanged.
  - On mem_ack=1 in either case: mem_req <= 0 and go to IDLE.
- DB holds its last loaded value at all other times.
- mem_ack while in IDLE is ignored.
- Reset:
  - State = IDLE; RDY=1; mem_req=0; mem_we=0.
  - mem_addr=16'h0000; mem_wdata=8'h00; DB=8'h00; bus_err=0; timeout counter=0.
- Reset during BUSY aborts the access:
  - mem_req is 0 in the cycle after the reset edge.
  - An ack arriving in that cycle or later is ignored.
  - Write data may or may not have been committed by memory; software must not rely on either outcome.
- Address arithmetic: none. The 16-bit address passes straight through; no wrap or carry handling is needed.

## Timing
- Core presents an access in cycle n (RDY=1); it is latched at the end of n.
- Cycle n+1: mem_req=1 and RDY=0.
- Ack sampled at the end of cycle k (k ≥ n+1).
- Cycle k+1: RDY=1, mem_req=0, DB holds the read data. The core consumes DB and presents its next access, which is latched at the end of k+1.
- Minimum access is 2 cycles (ack in the first BUSY cycle). Throughput is at most one access per 2 cycles.
- mem_req is low for exactly one cycle between back-to-back accesses.
- Memory handshake rule: address, we and wdata are stable from the first mem_req cycle through the ack cycle.

## Configuration
- Macro: BUS_BRIDGE_TIMEOUT_EN.
- **Defined:**
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT with no ack: go to IDLE and set mem_req=0.
  - For a read, DB <= 8'hFF. For a write, DB is unchanged.
  - bus_err=1 for exactly the cycle in which RDY returns to 1.
  - If ack and timeout occur in the same cycle, ack wins and bus_err stays 0.
- **Undefined:**
  - No counter; BUSY waits indefinitely for ack.
  - bus_err is constant 0.
  - TIMEOUT is ignored.

## Test plan
- Reset, then read $FFFC with ack in the first BUSY cycle:
  - mem_req high for 1 cycle with mem_addr=16'hFFFC and mem_we=0.
  - DB=mem_rdata (e.g. 8'h00) on the next cycle with RDY=1.
  - RDY=0 for exactly 1 cycle.
- Write $0200←8'h5A with ack delayed 3 cycles:
  - RDY=0 for 4 cycles.
  - mem_addr, mem_we=1 and mem_wdata=8'h5A stable throughout.
  - DB unchanged.
- Back-to-back reads $1000 then $1001 with immediate ack:
  - mem_req pattern 1,0,1.
  - DB values 8'h11 then 8'h22 each appear in the cycle RDY=1.
- RST asserted in the second cycle of a pending read, with ack asserted in the cycle after reset:
  - mem_req=0 and RDY=1 after the reset edge.
  - Ack ignored; DB=8'h00.
  - The next access latches the core's current AB.
- With BUS_BRIDGE_TIMEOUT_EN and TIMEOUT=4, no ack on a read of $D000:
  - Abort after 4 BUSY cycles.
  - DB=8'hFF and bus_err=1 for one cycle.
  - Repeat with ack arriving on the 4th BUSY cycle: DB=mem_rdata and bus_err=0.
- Without the macro, hold ack low for 1000 cycles:
  - RDY stays 0 and bus_err stays 0.
  - Late ack completes normally.
